// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM state encoding,
// transaction owner codes and bus widths.
package mem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_IF   = 2'd1;
    localparam logic [1:0] OWNER_D    = 2'd2;

    // The busy state doubles as the record of which port owns the memory.
    function automatic logic [1:0] state_owner(input arb_state_e st);
        logic [1:0] own;
        case (st)
            IF_BUSY: own = OWNER_IF;
            D_BUSY:  own = OWNER_D;
            default: own = OWNER_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the arbiter.
// The slave modport is the arbiter; master is the surrounding requesters and memory.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_be
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and data accesses; data is preferred but fetch wins after MAX_DATA_RUN data grants.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e        state_r;
    arb_state_e        state_nx_s;
    logic [CNT_W-1:0]  run_cnt_r;
    logic              run_full_s;
    logic              grant_if_s;
    logic              grant_d_s;
    logic              done_s;
    logic [1:0]        owner_s;

    logic              if_gnt_r;
    logic              if_rvalid_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic              d_gnt_r;
    logic              d_rvalid_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              m_req_r;
    logic              m_we_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wdata_r;
    logic [BE_W-1:0]   m_be_r;

    assign run_full_s = (run_cnt_r == RUN_MAX);
    assign owner_s    = state_owner(state_r);

    // Next-state and grant/complete decisions; m_ack only matters while busy.
    always_comb begin
        state_nx_s = state_r;
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && run_full_s)) begin
                    grant_d_s  = 1'b1;
                    state_nx_s = D_BUSY;
                end else if (bus.if_req) begin
                    grant_if_s = 1'b1;
                    state_nx_s = IF_BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (bus.m_ack) begin
                    done_s     = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Data-run counter: saturates while fetch is starved, cleared by a fetch grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_if_s) begin
            run_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_d_s && bus.if_req && !run_full_s) begin
            run_cnt_r <= run_cnt_r + CNT_ONE;
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // Memory command register; the command is left in place after completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= {ADDR_W{1'b0}};
            m_wdata_r <= {DATA_W{1'b0}};
            m_be_r    <= {BE_W{1'b0}};
        end else if (grant_d_s) begin
            m_req_r   <= 1'b1;
            m_we_r    <= bus.d_we;
            m_addr_r  <= bus.d_addr;
            m_wdata_r <= bus.d_wdata;
            m_be_r    <= bus.d_be;
        end else if (grant_if_s) begin
            m_req_r   <= 1'b1;
            m_we_r    <= 1'b0;
            m_addr_r  <= bus.if_addr;
            m_wdata_r <= {DATA_W{1'b0}};
            m_be_r    <= {BE_W{1'b1}};
        end else if (done_s) begin
            m_req_r   <= 1'b0;
        end else begin
            m_req_r   <= m_req_r;
        end
    end

    // Port-side grant and response pulses; read data holds until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_gnt_r    <= 1'b0;
            d_gnt_r     <= 1'b0;
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            if_gnt_r    <= grant_if_s;
            d_gnt_r     <= grant_d_s;
            if_rvalid_r <= done_s && (owner_s == OWNER_IF);
            d_rvalid_r  <= done_s && (owner_s == OWNER_D);
            if (done_s && (owner_s == OWNER_IF)) begin
                if_rdata_r <= bus.m_rdata;
            end
            if (done_s && (owner_s == OWNER_D)) begin
                d_rdata_r <= m_we_r ? {DATA_W{1'b0}} : bus.m_rdata;
            end
        end
    end

    assign bus.if_gnt    = if_gnt_r;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_gnt     = d_gnt_r;
    assign bus.d_rvalid  = d_rvalid_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.m_req     = m_req_r;
    assign bus.m_we      = m_we_r;
    assign bus.m_addr    = m_addr_r;
    assign bus.m_wdata   = m_wdata_r;
    assign bus.m_be      = m_be_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus sequences for
// arbitration fairness, a stalled memory ack and reset in the middle of a transaction.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        rst;
        logic        ifr;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        ack;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        ig;
        logic        dg;
        logic        iv;
        logic        dv;
        logic        mreq;
        logic        mwe;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic [3:0]  mbe;
        logic [31:0] ird;
        logic [31:0] drd;
    } exp_t;

    localparam int NVEC = 16;
    in_t  vin  [NVEC];
    exp_t vexp [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        reset       = v.rst;
        bus.if_req  = v.ifr;
        bus.if_addr = v.ia;
        bus.d_req   = v.dr;
        bus.d_we    = v.dwe;
        bus.d_addr  = v.da;
        bus.d_wdata = v.dwd;
        bus.d_be    = v.dbe;
        bus.m_ack   = v.ack;
        bus.m_rdata = v.mrd;
    endtask

    task automatic clear_inputs();
        drive('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0});
    endtask

    function automatic exp_t sample();
        exp_t a;
        a.ig   = bus.if_gnt;
        a.dg   = bus.d_gnt;
        a.iv   = bus.if_rvalid;
        a.dv   = bus.d_rvalid;
        a.mreq = bus.m_req;
        a.mwe  = bus.m_we;
        a.ma   = bus.m_addr;
        a.mwd  = bus.m_wdata;
        a.mbe  = bus.m_be;
        a.ird  = bus.if_rdata;
        a.drd  = bus.d_rdata;
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic exp_d [10];
    int   ng;

    initial begin
        // Inputs before an edge, expected outputs right after it.
        vin[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 32'h0};
        vexp[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 32'h0,        32'h0};
        vin[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 32'h0};
        vexp[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100,  32'h0,    4'hF, 32'h0,        32'h0};
        vin[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 32'h0};
        vexp[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100,  32'h0,    4'hF, 32'h0,        32'h0};
        vin[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b1, 32'hDEADBEEF};
        vexp[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100,  32'h0,    4'hF, 32'hDEADBEEF, 32'h0};
        vin[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 32'h0};
        vexp[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,  32'h0,    4'hF, 32'hDEADBEEF, 32'h0};
        vin[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h2000, 32'h55AA, 4'h3, 1'b0, 32'h0};
        vexp[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h55AA, 4'h3, 32'hDEADBEEF, 32'h0};
        vin[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b1, 32'h12345678};
        vexp[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h55AA, 4'h3, 32'hDEADBEEF, 32'h0};
        vin[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h3000, 32'h0,    4'hF, 1'b0, 32'h0};
        vexp[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0,    4'hF, 32'hDEADBEEF, 32'h0};
        vin[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b1, 32'hCAFEF00D};
        vexp[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 32'h0,    4'hF, 32'hDEADBEEF, 32'hCAFEF00D};
        vin[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b1, 32'h11111111};
        vexp[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3000, 32'h0,    4'hF, 32'hDEADBEEF, 32'hCAFEF00D};
        vin[10]  = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 32'h0};
        vexp[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0,    4'hF, 32'hDEADBEEF, 32'hCAFEF00D};
        vin[11]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b1, 32'hA5A5A5A5};
        vexp[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,    4'hF, 32'hA5A5A5A5, 32'hCAFEF00D};
        vin[12]  = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h50,   32'h0,    4'hF, 1'b0, 32'h0};
        vexp[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h50,  32'h0,    4'hF, 32'hA5A5A5A5, 32'hCAFEF00D};
        vin[13]  = '{1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b1, 32'h77};
        vexp[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h50,  32'h0,    4'hF, 32'hA5A5A5A5, 32'h77};
        vin[14]  = '{1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 32'h0};
        vexp[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44,  32'h0,    4'hF, 32'hA5A5A5A5, 32'h77};
        vin[15]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b1, 32'h88};
        vexp[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44,  32'h0,    4'hF, 32'h88,       32'h77};

        drive(vin[0]);
        for (int i = 0; i < NVEC; i++) begin
            drive(vin[i]);
            step();
            chk($sformatf("vec%0d", i), 256'(sample()), 256'(vexp[i]));
        end

        // Both ports requesting continuously: four data grants, then one fetch.
        do_reset();
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h600;
        bus.d_be    = 4'hF;
        bus.m_ack   = 1'b1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            step();
            chk("gnt_mutex", 256'(bus.if_gnt & bus.d_gnt), 256'(0));
            if (bus.if_gnt || bus.d_gnt) begin
                chk($sformatf("order%0d_is_data", ng), 256'(bus.d_gnt), 256'(exp_d[ng]));
                ng++;
            end
        end
        chk("order_grant_count", 256'(ng), 256'(10));

        // Memory stalls for five cycles; command must hold and nothing else is granted.
        do_reset();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h4000;
        bus.d_wdata = 32'hBEEF;
        bus.d_be    = 4'hC;
        step();
        chk("stall_gnt", 256'({bus.d_gnt, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be}),
            256'({1'b1, 1'b1, 1'b1, 32'h4000, 32'hBEEF, 4'hC}));
        bus.d_req   = 1'b0;
        bus.d_wdata = 32'h0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall_hold%0d", k),
                256'({bus.if_gnt, bus.d_gnt, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be, bus.d_rvalid}),
                256'({1'b0, 1'b0, 1'b1, 1'b1, 32'h4000, 32'hBEEF, 4'hC, 1'b0}));
        end
        bus.if_req  = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h999;
        step();
        chk("stall_done", 256'({bus.d_rvalid, bus.if_rvalid, bus.m_req, bus.d_rdata}),
            256'({1'b1, 1'b0, 1'b0, 32'h0}));
        bus.m_ack = 1'b0;

        // Reset two cycles into a data transaction abandons it.
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h700;
        bus.d_be    = 4'hF;
        step();
        chk("rst_gnt", 256'({bus.d_gnt, bus.if_gnt, bus.m_req}), 256'({1'b1, 1'b0, 1'b1}));
        chk("rst_runcnt_pre", 256'(dut.run_cnt_r), 256'(1));
        bus.d_req = 1'b0;
        step();
        reset       = 1'b1;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hBAD;
        step();
        chk("rst_abandon", 256'({bus.m_req, bus.d_rvalid, bus.if_rvalid, bus.d_gnt, bus.if_gnt, bus.d_rdata}),
            256'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        chk("rst_runcnt", 256'(dut.run_cnt_r), 256'(0));
        chk("rst_state", 256'(dut.state_r), 256'(IDLE));
        reset      = 1'b0;
        bus.if_req = 1'b0;
        step();
        chk("rst_spurious_ack", 256'({bus.d_rvalid, bus.if_rvalid, bus.m_req, bus.d_rdata}),
            256'({1'b0, 1'b0, 1'b0, 32'h0}));
        chk("rst_idle", 256'(dut.state_r), 256'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_DATA_RUN, default 4, consecutive data grants allowed while fetch is waiting before fetch wins.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch read request, held until if_gnt.
REQ-006 if_addr  in  32  fetch address, stable while if_req=1.
REQ-007 if_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-008 if_rvalid  out  1  one-cycle pulse: if_rdata valid.
REQ-009 if_rdata  out  32  fetched word.
REQ-010 d_req  in  1  data request (load or store, from MemRead/MemWrite), held until d_gnt.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_be  in  4  store byte enables.
REQ-015 d_gnt  out  1  one-cycle pulse: data request accepted.
REQ-016 d_rvalid  out  1  one-cycle pulse: load data valid or store complete.
REQ-017 d_rdata  out  32  load word; 0 after a store.
REQ-018 m_req  out  1  memory request, held until m_ack.
REQ-019 m_we, m_addr, m_wdata, m_be  out  1/32/32/4  registered memory command.
REQ-020 m_ack  in  1  memory completes the command this cycle.
REQ-021 m_rdata  in  32  read data, valid with m_ack.

Function
REQ-022 The FSM SHALL have the states IDLE, IF_BUSY and D_BUSY.
REQ-023 In IDLE with any request, the arbiter SHALL register the winner's command, assert its gnt on the next cycle and enter IF_BUSY or D_BUSY with m_req=1 in that cycle.
REQ-024 Only d_req set: data wins. Only if_req set: fetch wins.
REQ-025 Both set: data wins unless run_cnt==MAX_DATA_RUN, in which case fetch wins.
REQ-026 run_cnt SHALL increment, saturating at MAX_DATA_RUN, on a data grant while if_req=1, and SHALL clear on any fetch grant.
REQ-027 m_req and the m_* command SHALL remain constant in BUSY until m_ack=1.
REQ-028 On m_ack, m_rdata SHALL be registered and the owner's rvalid SHALL pulse on the next cycle; the FSM SHALL return to IDLE in that same next cycle.
REQ-029 Latency: request sampled at cycle N; gnt and m_req at N+1; if m_ack is at N+1, rvalid at N+2. Minimum spacing between grants is 2 cycles.
REQ-030 Fetch transactions SHALL drive m_we=0 and m_be=4'hF.
REQ-031 if_gnt and d_gnt SHALL never be high in the same cycle; likewise if_rvalid and d_rvalid.
REQ-032 At most one transaction SHALL be outstanding.
REQ-033 m_ack while in IDLE SHALL be ignored.
REQ-034 An if_rdata or d_rdata value SHALL hold until that port's next rvalid.

Reset
REQ-035 While reset=1, the following SHALL be 0 on the next edge: state=IDLE, run_cnt, m_req, m_we, m_addr, m_wdata, m_be, both gnt, both rvalid, if_rdata and d_rdata.
REQ-036 Reset during BUSY SHALL abandon the transaction with no rvalid, and m_req SHALL be 0 from the cycle after reset is sampled.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enum (IDLE, IF_BUSY, D_BUSY) and the owner encoding constants.
REQ-038 The block SHALL be a single module with the FSM and run_cnt inline; no sub-module is required.

Verification
REQ-039 Directed: fetch only, if_addr=0x100, m_ack one cycle after m_req, m_rdata=0xDEADBEEF -> if_gnt at N+1, if_rvalid and if_rdata=0xDEADBEEF at N+3.
REQ-040 Directed: store d_addr=0x2000, d_wdata=0x55AA, d_be=4'b0011 -> m_we=1 with identical fields, d_rvalid pulse, d_rdata=0.
REQ-041 Directed: if_req and d_req held high continuously, MAX_DATA_RUN=4 -> grant order D,D,D,D,I, then the pattern repeats.
REQ-042 Directed: m_ack delayed 5 cycles -> m_req and command stable for all 5 cycles, no second gnt.
REQ-043 Directed: reset asserted 2 cycles into D_BUSY -> m_req=0 the next cycle, no d_rvalid, run_cnt=0.
REQ-044 Directed: spurious m_ack in IDLE -> no rvalid, state remains IDLE.
